multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
Multi-cycle successor to the single-cycle opcode decoder. It sequences each RV32I instruction through fetch, decode, execute, memory and writeback states, and drives the datapath enables and muxes for R-type, I-ALU, LW, SW, BEQ and BNE. It handshakes with a shared instruction/data memory via mem_req/mem_ready, with a watchdog on memory stalls. It also counts retired instructions and flags illegal or timed-out operation in a sticky trap state. It sits between the instruction register and the shared-memory datapath.

Parameters:
ALU_CTRL_W, 3, width of alu_ctrl (encodings in package; must be >=3)
MAX_WAIT, 15, max cycles mem_req may stay unacknowledged before timeout trap (>=1)
RETIRE_W, 32, width of retired-instruction counter (wraps)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
opcode  in  7  instr[6:0] from instruction register
funct3  in  3  instr[14:12]
funct7_5  in  1  instr[30]
zero  in  1  ALU zero flag
mem_ready  in  1  memory acknowledges current request this cycle
pc_write  out  1  load PC
ir_write  out  1  load instruction register and old-PC
reg_write  out  1  regfile write enable
mem_req  out  1  memory request
mem_write  out  1  request is a store
adr_src  out  1  0=PC, 1=ALU-out register as memory address
alu_src_a  out  2  00=PC, 01=old PC, 10=rs1
alu_src_b  out  2  00=rs2, 01=imm, 10=constant 4
imm_src  out  2  00=I, 01=S, 10=B
result_src  out  2  00=ALU-out register, 01=mem data, 10=ALU result
alu_ctrl  out  ALU_CTRL_W  ALU operation
illegal  out  1  sticky trap flag
timeout  out  1  sticky; trap was caused by memory timeout
retired  out  RETIRE_W  count of completed instructions

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset: state=IDLE; wait counter=0; retired=0; illegal=0; timeout=0. All outputs are 0 while in IDLE. Reset mid-instruction aborts it with no write.
- IDLE -> FETCH unconditionally on the next edge.
- Outputs are Moore (decoded from state), except pc_write in BRANCH and the mem_ready-qualified strobes below.
- FETCH: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_ctrl=ADD.
  - ir_write and pc_write (result_src=10) assert only in the cycle mem_ready=1, then go to DECODE.
  - Otherwise hold in FETCH.
- DECODE: alu_src_a=01, alu_src_b=01, imm_src=10 (precompute branch target).
  - Next state by opcode: 0110011->EXEC_R; 0010011->EXEC_I; 0000011 or 0100011->MEM_ADDR; 1100011->BRANCH; else TRAP.
- EXEC_R: alu_src_a=10, alu_src_b=00; alu_ctrl from {funct7_5,funct3}. Goes to WB_ALU.
- EXEC_I: same as EXEC_R but alu_src_b=01, imm_src=00; funct7_5 ignored except SRLI/SLLI. Goes to WB_ALU.
  - Unsupported funct combination -> TRAP.
- ALU mapping: 0/000 ADD, 1/000 SUB (R only), 111 AND, 110 OR, 100 XOR, 010 SLT, 001 SLL, 0/101 SRL.
- MEM_ADDR: alu_src_a=10, alu_src_b=01, imm_src=00 for loads, 01 for stores, alu_ctrl=ADD. Goes to MEM_RD (load) or MEM_WR (store).
- MEM_RD: mem_req=1, adr_src=1. Goes to WB_MEM on mem_ready.
- MEM_WR: mem_req=1, mem_write=1, adr_src=1. Goes to FETCH on mem_ready; the store retires.
- WB_ALU: reg_write=1, result_src=00. Goes to FETCH; retires.
- WB_MEM: reg_write=1, result_src=01. Goes to FETCH; retires.
- BRANCH: alu_src_a=10, alu_src_b=00, alu_ctrl=SUB, result_src=00.
  - funct3 000 (BEQ): pc_write=zero. funct3 001 (BNE): pc_write=~zero.
  - Goes to FETCH; retires. Other funct3 -> TRAP with no pc_write.
- Wait counter:
  - Increments each cycle in FETCH/MEM_RD/MEM_WR while mem_ready=0; clears on any state change.
  - If it reaches MAX_WAIT with mem_ready=0: go to TRAP and set timeout=1.
  - mem_ready=1 on the MAX_WAIT cycle is accepted normally (ready wins).
- TRAP: illegal=1, all strobes 0; absorbing until rst.
- Latency with zero-wait memory (cycles per instruction): R/I = 4, LW = 5, SW = 4, branch = 3.
- retired increments by 1 on each retiring transition and wraps modulo 2^RETIRE_W.
- mem_req stays asserted and address/control stay stable throughout a stall.

Decomposition:
- Package mcu_pkg holds:
  - state_t enum {IDLE, FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, TRAP};
  - opcode localparams;
  - alu_ctrl encodings (ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5, SLL=6, SRL=7);
  - src-mux encodings.
- One sub-module, alu_decoder, is natural: combinational {is_r, funct7_5, funct3} -> {alu_ctrl, legal}.

Test Plan:
- ADDI (0010011, f3=000), mem_ready tied 1 -> FETCH, DECODE, EXEC_I, WB_ALU; reg_write=1 only in cycle 4, alu_ctrl=0; retired 0->1.
- LW with mem_ready low 3 cycles in MEM_RD -> state holds, mem_req=1, adr_src=1 stable; WB_MEM follows the ready cycle; total 8 cycles.
- BNE with zero=0 -> pc_write=1 in BRANCH. Same instruction with zero=1 -> pc_write=0. BEQ gives the inverse; each takes 3 cycles.
- opcode 1111111 -> TRAP after DECODE; illegal=1, timeout=0, all strobes 0 for 20 cycles; rst clears it and the next edge goes IDLE->FETCH.
- mem_ready held 0 in FETCH, MAX_WAIT=15 -> TRAP after 15 waiting cycles, timeout=1. Rerun with ready on cycle 15 -> no trap.
- rst asserted mid-MEM_WR (asynchronous, between edges) -> mem_req/mem_write drop immediately; retired=0.

Source files
------------

// File: rtl/mcu_pkg.sv
// Shared types and encodings for the multicycle control unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mcu_pkg;

    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR,
        MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, TRAP
    } state_t;

    // RV32I major opcodes handled here
    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2, ALU_OR  = 3'd3,
        ALU_XOR = 3'd4, ALU_SLT = 3'd5, ALU_SLL = 3'd6, ALU_SRL = 3'd7
    } alu_op_t;

    // Datapath mux selects
    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] SRC_A_RS1   = 2'b10;

    localparam logic [1:0] SRC_B_RS2   = 2'b00;
    localparam logic [1:0] SRC_B_IMM   = 2'b01;
    localparam logic [1:0] SRC_B_FOUR  = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/multicycle_control_unit_alu_decoder.sv
// ALU operation decoder: {is_r, funct7_5, funct3} -> {alu_op, legal}.
// Latency: purely combinational.
// Backpressure: none; ports: is_r, funct7_5, funct3 in; alu_op, legal out.
module alu_decoder
    import mcu_pkg::*;
(
    input  logic       is_r,
    input  logic       funct7_5,
    input  logic [2:0] funct3,
    output alu_op_t    alu_op,
    output logic       legal
);

    always_comb begin
        alu_op = ALU_ADD;
        legal  = 1'b1;
        case (funct3)
            // instr[30] is an immediate bit for ADDI, so SUB is R-type only
            3'b000: alu_op = (is_r && funct7_5) ? ALU_SUB : ALU_ADD;
            3'b111: begin alu_op = ALU_AND; legal = !(is_r && funct7_5); end
            3'b110: begin alu_op = ALU_OR;  legal = !(is_r && funct7_5); end
            3'b100: begin alu_op = ALU_XOR; legal = !(is_r && funct7_5); end
            3'b010: begin alu_op = ALU_SLT; legal = !(is_r && funct7_5); end
            // shifts: instr[30] selects arithmetic variants, which are not supported
            3'b001: begin alu_op = ALU_SLL; legal = !funct7_5; end
            3'b101: begin alu_op = ALU_SRL; legal = !funct7_5; end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control FSM driving datapath enables/muxes over a shared memory.
// Latency: R/I 4, LW 5, SW 4, branch 3 cycles with zero-wait memory.
// Backpressure: mem_ready low holds FETCH/MEM_RD/MEM_WR stable; MAX_WAIT stall cycles -> sticky timeout trap.
// Ports: clk/rst; opcode/funct3/funct7_5 from IR; zero flag; mem_ready handshake;
//        datapath strobes and mux selects; illegal/timeout trap flags; retired counter.
module multicycle_control_unit
    import mcu_pkg::*;
#(
    parameter int ALU_CTRL_W = 3,
    parameter int MAX_WAIT   = 15,
    parameter int RETIRE_W   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            opcode,
    input  logic [2:0]            funct3,
    input  logic                  funct7_5,
    input  logic                  zero,
    input  logic                  mem_ready,
    output logic                  pc_write,
    output logic                  ir_write,
    output logic                  reg_write,
    output logic                  mem_req,
    output logic                  mem_write,
    output logic                  adr_src,
    output logic [1:0]            alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [1:0]            imm_src,
    output logic [1:0]            result_src,
    output logic [ALU_CTRL_W-1:0] alu_ctrl,
    output logic                  illegal,
    output logic                  timeout,
    output logic [RETIRE_W-1:0]   retired
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    state_t            state, next_state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              mem_state;
    logic              wait_expired;
    logic              retire;
    alu_op_t           dec_op, alu_op;
    logic              dec_legal;

    alu_decoder u_alu_decoder (
        .is_r     (state == EXEC_R),
        .funct7_5 (funct7_5),
        .funct3   (funct3),
        .alu_op   (dec_op),
        .legal    (dec_legal)
    );

    assign mem_state = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
    // wait_cnt counts stall cycles already spent, so this is the MAX_WAIT-th one
    assign wait_expired = mem_state && !mem_ready && (wait_cnt == WAIT_W'(MAX_WAIT - 1));

    always_comb begin
        next_state = state;
        retire     = 1'b0;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_RS2;
        imm_src    = IMM_I;
        result_src = RES_ALUOUT;
        alu_op     = ALU_ADD;
        case (state)
            IDLE: next_state = FETCH;
            FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = SRC_B_FOUR;
                result_src = RES_ALU;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    next_state = DECODE;
                end else if (wait_expired) begin
                    next_state = TRAP;
                end
            end
            DECODE: begin
                // branch target computed speculatively into the ALU-out register
                alu_src_a = SRC_A_OLDPC;
                alu_src_b = SRC_B_IMM;
                imm_src   = IMM_B;
                case (opcode)
                    OP_R:         next_state = EXEC_R;
                    OP_I:         next_state = EXEC_I;
                    OP_LW, OP_SW: next_state = MEM_ADDR;
                    OP_BR:        next_state = BRANCH;
                    default:      next_state = TRAP;
                endcase
            end
            EXEC_R: begin
                alu_src_a  = SRC_A_RS1;
                alu_op     = dec_op;
                next_state = dec_legal ? WB_ALU : TRAP;
            end
            EXEC_I: begin
                alu_src_a  = SRC_A_RS1;
                alu_src_b  = SRC_B_IMM;
                alu_op     = dec_op;
                next_state = dec_legal ? WB_ALU : TRAP;
            end
            MEM_ADDR: begin
                alu_src_a  = SRC_A_RS1;
                alu_src_b  = SRC_B_IMM;
                imm_src    = (opcode == OP_SW) ? IMM_S : IMM_I;
                next_state = (opcode == OP_SW) ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (mem_ready)         next_state = WB_MEM;
                else if (wait_expired) next_state = TRAP;
            end
            MEM_WR: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
                if (mem_ready) begin
                    next_state = FETCH;
                    retire     = 1'b1;
                end else if (wait_expired) begin
                    next_state = TRAP;
                end
            end
            WB_ALU: begin
                reg_write  = 1'b1;
                next_state = FETCH;
                retire     = 1'b1;
            end
            WB_MEM: begin
                reg_write  = 1'b1;
                result_src = RES_MEM;
                next_state = FETCH;
                retire     = 1'b1;
            end
            BRANCH: begin
                alu_src_a = SRC_A_RS1;
                alu_op    = ALU_SUB;
                case (funct3)
                    F3_BEQ: begin pc_write = zero;  next_state = FETCH; retire = 1'b1; end
                    F3_BNE: begin pc_write = !zero; next_state = FETCH; retire = 1'b1; end
                    default: next_state = TRAP;
                endcase
            end
            TRAP:    next_state = TRAP;
            default: next_state = TRAP;
        endcase
    end

    assign alu_ctrl = ALU_CTRL_W'(alu_op);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
            retired  <= '0;
            illegal  <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state <= next_state;
            if (next_state != state)
                wait_cnt <= '0;
            else if (mem_state && !mem_ready)
                wait_cnt <= wait_cnt + WAIT_W'(1);
            if (retire)
                retired <= retired + RETIRE_W'(1);
            if (next_state == TRAP)
                illegal <= 1'b1;
            if (wait_expired)
                timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: stimulus pushes per-cycle expected outputs, monitor compares.
// Latency: expectations are pushed just after each edge and checked on the following falling edge.
// Backpressure: mem_ready is driven per cycle by the directed vectors.
module tb_multicycle_control_unit;

    typedef struct packed {
        logic       pc_write, ir_write, reg_write, mem_req, mem_write, adr_src;
        logic [1:0] alu_src_a, alu_src_b, imm_src, result_src;
        logic [2:0] alu_ctrl;
        logic       illegal, timeout;
    } obs_t;

    // hand-derived output vectors per phase
    //                           pcw   irw   rw    mr    mw    as    a     b     imm   res   alu   ill   to
    localparam obs_t P_IDLE    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,3'd0,1'b0,1'b0};
    localparam obs_t P_F_RDY   = {1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,2'b00,2'b10,2'b00,2'b10,3'd0,1'b0,1'b0};
    localparam obs_t P_F_WAIT  = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,2'b10,2'b00,2'b10,3'd0,1'b0,1'b0};
    localparam obs_t P_DEC     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b01,2'b10,2'b00,3'd0,1'b0,1'b0};
    localparam obs_t P_EXI_ADD = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b01,2'b00,2'b00,3'd0,1'b0,1'b0};
    localparam obs_t P_EXI_XOR = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b01,2'b00,2'b00,3'd4,1'b0,1'b0};
    localparam obs_t P_EXI_SLL = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b01,2'b00,2'b00,3'd6,1'b0,1'b0};
    localparam obs_t P_EXR_SUB = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b00,2'b00,3'd1,1'b0,1'b0};
    localparam obs_t P_EXR_AND = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b00,2'b00,3'd2,1'b0,1'b0};
    localparam obs_t P_EXR_SRL = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b00,2'b00,3'd7,1'b0,1'b0};
    localparam obs_t P_EXR_SLT = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b00,2'b00,3'd5,1'b0,1'b0};
    localparam obs_t P_MA_LW   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b01,2'b00,2'b00,3'd0,1'b0,1'b0};
    localparam obs_t P_MA_SW   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b01,2'b01,2'b00,3'd0,1'b0,1'b0};
    localparam obs_t P_MRD     = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,2'b00,2'b00,2'b00,2'b00,3'd0,1'b0,1'b0};
    localparam obs_t P_MWR     = {1'b0,1'b0,1'b0,1'b1,1'b1,1'b1,2'b00,2'b00,2'b00,2'b00,3'd0,1'b0,1'b0};
    localparam obs_t P_WBA     = {1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,3'd0,1'b0,1'b0};
    localparam obs_t P_WBM     = {1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b01,3'd0,1'b0,1'b0};
    localparam obs_t P_BR_T    = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b00,2'b00,3'd1,1'b0,1'b0};
    localparam obs_t P_BR_N    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b00,2'b00,3'd1,1'b0,1'b0};
    localparam obs_t P_TRAP    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,3'd0,1'b1,1'b0};
    localparam obs_t P_TRAP_TO = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,3'd0,1'b1,1'b1};

    localparam logic [6:0] OPC_R  = 7'b0110011;
    localparam logic [6:0] OPC_I  = 7'b0010011;
    localparam logic [6:0] OPC_LW = 7'b0000011;
    localparam logic [6:0] OPC_SW = 7'b0100011;
    localparam logic [6:0] OPC_BR = 7'b1100011;
    localparam logic [6:0] OPC_XX = 7'b1111111;

    logic        clk, rst;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_5, zero, mem_ready;
    logic        pc_write, ir_write, reg_write, mem_req, mem_write, adr_src;
    logic [1:0]  alu_src_a, alu_src_b, imm_src, result_src;
    logic [2:0]  alu_ctrl;
    logic        illegal, timeout;
    logic [31:0] retired;

    multicycle_control_unit #(.ALU_CTRL_W(3), .MAX_WAIT(15), .RETIRE_W(32)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
        .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
        .reg_write(reg_write), .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
        .result_src(result_src), .alu_ctrl(alu_ctrl), .illegal(illegal),
        .timeout(timeout), .retired(retired)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    obs_t        exp_q[$];
    logic [31:0] ret_q[$];
    string       name_q[$];
    logic [31:0] exp_ret;
    int          checks;
    int          errors;
    event        sample_ev;

    // monitor: compares on every falling edge (or on demand) whenever an expectation is queued
    initial begin
        forever begin
            obs_t        e, act;
            logic [31:0] r;
            string       n;
            @(negedge clk or sample_ev);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                r = ret_q.pop_front();
                n = name_q.pop_front();
                act = {pc_write, ir_write, reg_write, mem_req, mem_write, adr_src,
                       alu_src_a, alu_src_b, imm_src, result_src, alu_ctrl, illegal, timeout};
                checks++;
                if (act !== e || retired !== r) begin
                    errors++;
                    $display("FAIL %s: got outputs=%05h retired=%0d, want outputs=%05h retired=%0d",
                             n, act, retired, e, r);
                end
            end
        end
    end

    task automatic push(input obs_t e, input string n);
        exp_q.push_back(e);
        ret_q.push_back(exp_ret);
        name_q.push_back(n);
    endtask

    task automatic step(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                        input logic z, input logic rdy, input obs_t e, input string n,
                        input bit ret);
        @(posedge clk);
        #1;
        opcode = op; funct3 = f3; funct7_5 = f7; zero = z; mem_ready = rdy;
        push(e, n);
        if (ret) exp_ret++;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_ret = '0;
        push(P_IDLE, "reset_held");
        @(posedge clk);
        #1;
        rst = 1'b0;
        push(P_IDLE, "idle_after_reset");
    endtask

    task automatic run_alu(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input obs_t ex, input string n, input int fwait);
        for (int i = 0; i < fwait; i++) step(op, f3, f7, 1'b0, 1'b0, P_F_WAIT, {n, "_fetch_wait"}, 0);
        step(op, f3, f7, 1'b0, 1'b1, P_F_RDY, {n, "_fetch"}, 0);
        step(op, f3, f7, 1'b0, 1'b1, P_DEC,   {n, "_decode"}, 0);
        step(op, f3, f7, 1'b0, 1'b1, ex,      {n, "_exec"}, 0);
        step(op, f3, f7, 1'b0, 1'b1, P_WBA,   {n, "_wb"}, 1);
    endtask

    task automatic run_branch(input logic [2:0] f3, input logic z, input obs_t br, input string n);
        step(OPC_BR, f3, 1'b0, z, 1'b1, P_F_RDY, {n, "_fetch"}, 0);
        step(OPC_BR, f3, 1'b0, z, 1'b1, P_DEC,   {n, "_decode"}, 0);
        step(OPC_BR, f3, 1'b0, z, 1'b1, br,      {n, "_branch"}, 1);
    endtask

    initial begin
        checks = 0; errors = 0; exp_ret = '0;
        rst = 1'b1; opcode = '0; funct3 = '0; funct7_5 = 1'b0; zero = 1'b0; mem_ready = 1'b1;

        do_reset();

        // ALU instructions, zero-wait memory
        run_alu(OPC_I, 3'b000, 1'b0, P_EXI_ADD, "addi", 0);
        run_alu(OPC_R, 3'b000, 1'b1, P_EXR_SUB, "sub", 0);
        run_alu(OPC_R, 3'b111, 1'b0, P_EXR_AND, "and", 0);
        run_alu(OPC_R, 3'b101, 1'b0, P_EXR_SRL, "srl", 0);
        run_alu(OPC_R, 3'b010, 1'b0, P_EXR_SLT, "slt", 0);
        run_alu(OPC_I, 3'b100, 1'b1, P_EXI_XOR, "xori_f7_ignored", 0);
        run_alu(OPC_I, 3'b001, 1'b0, P_EXI_SLL, "slli", 0);

        // LW with three stall cycles in MEM_RD: 8 cycles total
        step(OPC_LW, 3'b010, 1'b0, 1'b0, 1'b1, P_F_RDY, "lw_fetch", 0);
        step(OPC_LW, 3'b010, 1'b0, 1'b0, 1'b1, P_DEC,   "lw_decode", 0);
        step(OPC_LW, 3'b010, 1'b0, 1'b0, 1'b1, P_MA_LW, "lw_addr", 0);
        for (int i = 0; i < 3; i++) step(OPC_LW, 3'b010, 1'b0, 1'b0, 1'b0, P_MRD, "lw_rd_stall", 0);
        step(OPC_LW, 3'b010, 1'b0, 1'b0, 1'b1, P_MRD, "lw_rd_ready", 0);
        step(OPC_LW, 3'b010, 1'b0, 1'b0, 1'b1, P_WBM, "lw_wb", 1);

        // SW, zero-wait
        step(OPC_SW, 3'b010, 1'b0, 1'b0, 1'b1, P_F_RDY, "sw_fetch", 0);
        step(OPC_SW, 3'b010, 1'b0, 1'b0, 1'b1, P_DEC,   "sw_decode", 0);
        step(OPC_SW, 3'b010, 1'b0, 1'b0, 1'b1, P_MA_SW, "sw_addr", 0);
        step(OPC_SW, 3'b010, 1'b0, 1'b0, 1'b1, P_MWR,   "sw_write", 1);

        // branches
        run_branch(3'b001, 1'b0, P_BR_T, "bne_z0");
        run_branch(3'b001, 1'b1, P_BR_N, "bne_z1");
        run_branch(3'b000, 1'b1, P_BR_T, "beq_z1");
        run_branch(3'b000, 1'b0, P_BR_N, "beq_z0");

        // ready on the 15th fetch cycle is accepted
        run_alu(OPC_I, 3'b000, 1'b0, P_EXI_ADD, "addi_ready_at_max", 14);

        // illegal opcode traps after DECODE and stays trapped
        step(OPC_XX, 3'b000, 1'b0, 1'b0, 1'b1, P_F_RDY, "bad_fetch", 0);
        step(OPC_XX, 3'b000, 1'b0, 1'b0, 1'b1, P_DEC,   "bad_decode", 0);
        for (int i = 0; i < 20; i++) step(OPC_XX, 3'b000, 1'b0, 1'b0, 1'b1, P_TRAP, "bad_trap_hold", 0);

        // reset clears the trap and IDLE -> FETCH follows
        do_reset();
        // unsupported branch funct3: no pc_write, then trap
        step(OPC_BR, 3'b010, 1'b0, 1'b1, 1'b1, P_F_RDY, "badbr_fetch", 0);
        step(OPC_BR, 3'b010, 1'b0, 1'b1, 1'b1, P_DEC,   "badbr_decode", 0);
        step(OPC_BR, 3'b010, 1'b0, 1'b1, 1'b1, P_BR_N,  "badbr_branch", 0);
        for (int i = 0; i < 3; i++) step(OPC_BR, 3'b010, 1'b0, 1'b1, 1'b1, P_TRAP, "badbr_trap", 0);

        // fetch never acknowledged: trap with timeout after 15 waiting cycles
        do_reset();
        for (int i = 0; i < 15; i++) step(OPC_I, 3'b000, 1'b0, 1'b0, 1'b0, P_F_WAIT, "to_fetch_wait", 0);
        for (int i = 0; i < 3; i++)  step(OPC_I, 3'b000, 1'b0, 1'b0, 1'b1, P_TRAP_TO, "to_trap", 0);

        // asynchronous reset in the middle of a stalled store
        do_reset();
        run_alu(OPC_I, 3'b000, 1'b0, P_EXI_ADD, "addi_pre_rst", 0);
        step(OPC_SW, 3'b010, 1'b0, 1'b0, 1'b1, P_F_RDY, "sw2_fetch", 0);
        step(OPC_SW, 3'b010, 1'b0, 1'b0, 1'b1, P_DEC,   "sw2_decode", 0);
        step(OPC_SW, 3'b010, 1'b0, 1'b0, 1'b1, P_MA_SW, "sw2_addr", 0);
        step(OPC_SW, 3'b010, 1'b0, 1'b0, 1'b0, P_MWR,   "sw2_stall", 0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        exp_ret = '0;
        push(P_IDLE, "async_rst_mid_store");
        ->sample_ev;
        @(posedge clk);
        #1;
        rst = 1'b0;
        push(P_IDLE, "idle_after_async_rst");
        step(OPC_I, 3'b000, 1'b0, 1'b0, 1'b1, P_F_RDY, "fetch_after_async_rst", 0);

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
